adam_rst_seq: RTL and testbench

- Parametrised reset sequencer for FPGA top levels.
- Generalises the fixed 4-bit power-on reset stretch into per-channel reset outputs. Channels are released in order with a fixed gap between them.
- Synchronises an external active-low button reset.
- Supports per-channel soft reset after bring-up.
- Drives the rst of each ADAM_SEQ domain (lsdom, hsdom, lpmem, mems).

---
 rtl/adam_rst_seq_pkg.sv | 28 ++
 rtl/adam_rst_sync.sv | 30 +++
 rtl/adam_rst_seq.sv | 175 +++++++++++++++++
 tb/tb_adam_rst_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adam_rst_seq_pkg.sv
// Shared types and parameter sanity helpers for the ADAM reset sequencer.
// Board tops may import this for the state encoding and counter type.
package adam_rst_seq_pkg;

    localparam int DEF_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_e;

    typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

    // A cycle count is usable when a CNT_WIDTH-bit equality compare can reach it.
    function automatic bit cycles_in_range(int cycles, int width);
        return (width >= 1) && (width < 31) && (cycles >= 1) && (cycles < (1 << width));
    endfunction

    function automatic bit params_ok(int no_channels, int cnt_width, int hold_cycles,
                                     int stage_delay, int soft_cycles, int sync_stages);
        return (no_channels >= 1) && (sync_stages >= 2)
            && cycles_in_range(hold_cycles, cnt_width)
            && cycles_in_range(stage_delay, cnt_width)
            && cycles_in_range(soft_cycles, cnt_width);
    endfunction

endpackage

// File: rtl/adam_rst_sync.sv
// N-stage synchroniser for an asynchronous single-bit input.
// Flops clear to 0, so an active-low input reads as asserted during reset.
module adam_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/adam_rst_seq.sv
// Reset sequencer: holds all channels after the board reset, releases them in
// order with a fixed gap, then offers per-channel soft reset pulses.
module adam_rst_seq
    import adam_rst_seq_pkg::*;
#(
    parameter int NO_CHANNELS = 4,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 4,
    parameter int SOFT_CYCLES = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ext_rstn,
    input  logic [NO_CHANNELS-1:0] ch_req,
    output logic [NO_CHANNELS-1:0] ch_rst,
    output logic                   all_released,
    output logic                   busy
);

    localparam int IDX_WIDTH = $clog2(NO_CHANNELS + 1);

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STAGE_LAST = CNT_WIDTH'(STAGE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] SOFT_LAST  = CNT_WIDTH'(SOFT_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST   = IDX_WIDTH'(NO_CHANNELS - 1);

    if (!params_ok(NO_CHANNELS, CNT_WIDTH, HOLD_CYCLES, STAGE_DELAY, SOFT_CYCLES,
                   SYNC_STAGES)) begin : g_param_err
        $error("adam_rst_seq: parameter out of range");
    end

    logic ext_ok;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   soft_cnt_q [NO_CHANNELS];
    logic [CNT_WIDTH-1:0]   soft_cnt_d [NO_CHANNELS];
    logic [NO_CHANNELS-1:0] ch_rst_q, ch_rst_d;
    logic                   all_released_q, all_released_d;
    logic                   busy_q, busy_d;

    adam_rst_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk(clk),
        .rst(rst),
        .d  (ext_rstn),
        .q  (ext_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= HOLD;
            cnt_q          <= '0;
            idx_q          <= '0;
            ch_rst_q       <= '1;
            all_released_q <= 1'b0;
            busy_q         <= 1'b1;
            // NOTE: the soft counters are a handful of flops, not a RAM, so they take the async reset like everything else.
            for (int i = 0; i < NO_CHANNELS; i++) begin
                soft_cnt_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            ch_rst_q       <= ch_rst_d;
            all_released_q <= all_released_d;
            busy_q         <= busy_d;
            for (int i = 0; i < NO_CHANNELS; i++) begin
                soft_cnt_q[i] <= soft_cnt_d[i];
            end
        end
    end

    // Sequencing: hold counter, stage counter and release index.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!ext_ok) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        idx_d   = IDX_WIDTH'(1);
                        state_d = (NO_CHANNELS == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    // Channel resets, soft-reset counters and status flags.
    always_comb begin
        ch_rst_d = ch_rst_q;
        for (int i = 0; i < NO_CHANNELS; i++) begin
            soft_cnt_d[i] = soft_cnt_q[i];
        end
        if (!ext_ok) begin
            ch_rst_d = '1;
            for (int i = 0; i < NO_CHANNELS; i++) begin
                soft_cnt_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        ch_rst_d[0] = 1'b0;
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        for (int i = 0; i < NO_CHANNELS; i++) begin
                            if (IDX_WIDTH'(i) == idx_q) begin
                                ch_rst_d[i] = 1'b0;
                            end
                        end
                    end
                end
                RUN: begin
                    // A request while a pulse is running reloads it, extending the pulse.
                    for (int i = 0; i < NO_CHANNELS; i++) begin
                        if (ch_req[i]) begin
                            ch_rst_d[i]   = 1'b1;
                            soft_cnt_d[i] = SOFT_LAST;
                        end else if (ch_rst_q[i]) begin
                            if (soft_cnt_q[i] == '0) begin
                                ch_rst_d[i] = 1'b0;
                            end else begin
                                soft_cnt_d[i] = soft_cnt_q[i] - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    ch_rst_d = '1;
                end
            endcase
        end
        all_released_d = (state_d == RUN) && (ch_rst_d == '0);
        busy_d         = (state_d != RUN);
    end

    assign ch_rst       = ch_rst_q;
    assign all_released = all_released_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_adam_rst_seq.sv
// Directed bench for adam_rst_seq: release timing, board-reset restart,
// soft reset pulses, async reset and a single-channel build.
module tb_adam_rst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       ext_rstn;
    logic [3:0] ch_req;
    logic [3:0] ch_rst;
    logic       all_released;
    logic       busy;

    logic       rst1;
    logic       ext_rstn1;
    logic [0:0] ch_req1;
    logic [0:0] ch_rst1;
    logic       all_released1;
    logic       busy1;

    int vectors     = 0;
    int miscompares = 0;

    adam_rst_seq dut (
        .clk         (clk),
        .rst         (rst),
        .ext_rstn    (ext_rstn),
        .ch_req      (ch_req),
        .ch_rst      (ch_rst),
        .all_released(all_released),
        .busy        (busy)
    );

    adam_rst_seq #(
        .NO_CHANNELS(1),
        .HOLD_CYCLES(1)
    ) dut1 (
        .clk         (clk),
        .rst         (rst1),
        .ext_rstn    (ext_rstn1),
        .ch_req      (ch_req1),
        .ch_rst      (ch_rst1),
        .all_released(all_released1),
        .busy        (busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Expected {ch_rst, all_released, busy} after edge e of a clean bring-up.
    function automatic logic [5:0] bringup_exp(input int e);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) begin
            m[k] = (e < 18 + 4 * k);
        end
        return {m, (e >= 30), (e < 30)};
    endfunction

    // Holds rst for two edges, then releases it so the next edge is edge 1.
    task automatic start_seq();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        ext_rstn = 1'b1;
        ch_req   = '0;
        rst      = 1'b1;
        steps(2);
        got = {ch_rst, all_released, busy};
        if (got !== 6'b1111_0_1) begin
            $display("FAIL reset_values: got %b expected %b", got, 6'b1111_0_1);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_bringup();
        logic [5:0] got, exp;
        ext_rstn = 1'b1;
        ch_req   = '0;
        start_seq();
        for (int e = 1; e <= 32; e++) begin
            step();
            got = {ch_rst, all_released, busy};
            exp = bringup_exp(e);
            if (got !== exp) begin
                $display("FAIL bringup edge %0d: got %b expected %b", e, got, exp);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_req_ignored();
        logic [5:0] got, exp;
        ext_rstn = 1'b1;
        ch_req   = 4'hF;
        start_seq();
        for (int e = 1; e <= 30; e++) begin
            step();
            got = {ch_rst, all_released, busy};
            exp = bringup_exp(e);
            if (got !== exp) begin
                $display("FAIL req_ignored edge %0d: got %b expected %b", e, got, exp);
                miscompares++;
            end
            vectors++;
        end
        step();
        got = {ch_rst, all_released, busy};
        if (got !== 6'b1111_0_0) begin
            $display("FAIL req_first_run_edge: got %b expected %b", got, 6'b1111_0_0);
            miscompares++;
        end
        vectors++;
        ch_req = '0;
        for (int i = 1; i <= 8; i++) begin
            step();
            got = {ch_rst, all_released, busy};
            exp = (i < 8) ? 6'b1111_0_0 : 6'b0000_1_0;
            if (got !== exp) begin
                $display("FAIL req_all_pulse +%0d: got %b expected %b", i, got, exp);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_ext_drop();
        logic [5:0] got, exp;
        ext_rstn = 1'b1;
        ch_req   = '0;
        start_seq();
        steps(23);
        ext_rstn = 1'b0;
        for (int e = 24; e <= 26; e++) begin
            step();
            got = {ch_rst, all_released, busy};
            exp = (e < 26) ? 6'b1100_0_1 : 6'b1111_0_1;
            if (got !== exp) begin
                $display("FAIL ext_drop edge %0d: got %b expected %b", e, got, exp);
                miscompares++;
            end
            vectors++;
        end
        ext_rstn = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            step();
            got = {ch_rst, all_released, busy};
            exp = bringup_exp(j);
            if (got !== exp) begin
                $display("FAIL ext_restart +%0d: got %b expected %b", j, got, exp);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_soft_single();
        logic [5:0] got, exp;
        ch_req = 4'b0100;
        step();
        ch_req = '0;
        got = {ch_rst, all_released, busy};
        if (got !== 6'b0100_0_0) begin
            $display("FAIL soft_single start: got %b expected %b", got, 6'b0100_0_0);
            miscompares++;
        end
        vectors++;
        for (int i = 1; i <= 8; i++) begin
            step();
            got = {ch_rst, all_released, busy};
            exp = (i < 8) ? 6'b0100_0_0 : 6'b0000_1_0;
            if (got !== exp) begin
                $display("FAIL soft_single +%0d: got %b expected %b", i, got, exp);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_soft_extend();
        logic [5:0] got, exp;
        ch_req = 4'b0010;
        step();
        ch_req = '0;
        for (int i = 1; i <= 13; i++) begin
            ch_req = (i == 5) ? 4'b0010 : 4'b0000;
            step();
            got = {ch_rst, all_released, busy};
            exp = (i < 13) ? 6'b0010_0_0 : 6'b0000_1_0;
            if (got !== exp) begin
                $display("FAIL soft_extend +%0d: got %b expected %b", i, got, exp);
                miscompares++;
            end
            vectors++;
        end
        ch_req = '0;
    endtask

    task automatic test_async_rst();
        logic [5:0] got;
        ext_rstn = 1'b1;
        ch_req   = '0;
        start_seq();
        steps(20);
        got = {ch_rst, all_released, busy};
        if (got !== 6'b1110_0_1) begin
            $display("FAIL async_pre: got %b expected %b", got, 6'b1110_0_1);
            miscompares++;
        end
        vectors++;
        #2;
        rst = 1'b1;
        #1;
        got = {ch_rst, all_released, busy};
        if (got !== 6'b1111_0_1) begin
            $display("FAIL async_rst: got %b expected %b", got, 6'b1111_0_1);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_single_channel();
        logic [2:0] got, exp;
        ext_rstn1 = 1'b1;
        ch_req1   = '0;
        step();
        rst1 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            got = {ch_rst1, all_released1, busy1};
            exp = (e < 3) ? 3'b1_0_1 : 3'b0_1_0;
            if (got !== exp) begin
                $display("FAIL single_ch edge %0d: got %b expected %b", e, got, exp);
                miscompares++;
            end
            vectors++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        ext_rstn  = 1'b1;
        ch_req    = '0;
        rst1      = 1'b1;
        ext_rstn1 = 1'b1;
        ch_req1   = '0;
        test_reset();
        test_bringup();
        test_req_ignored();
        test_ext_drop();
        test_soft_single();
        test_soft_extend();
        test_async_rst();
        test_single_channel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
